// File: rtl/emu_time_sched.sv
// emu_time_sched -- global event scheduler for the emulation time base.
//
// Every event slot the block scans the packed source times one per cycle,
// keeps the unsigned minimum (lowest index wins ties), and broadcasts it on
// time_next together with a one-cycle emu_cke. Run/halt, single-step and an
// optional breakpoint let the host pause emulated time.
//
// Optional feature: define EMU_TIME_SCHED_BREAKPOINT_EN to build the
// stop_en/stop_time breakpoint. Without it those ports are ignored and
// stop_hit stays 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   run          free-run enable (level)
//   step_req     single-event request pulse, honoured only while halted
//   stop_en      breakpoint enable
//   stop_time    breakpoint time
//   src_time     packed source times, source i at [i*TIME_WIDTH +: TIME_WIDTH]
//   time_next    registered broadcast event time (all-ones after reset)
//   emu_cke      one-cycle strobe per issued event, aligned with time_next
//   min_idx      lowest index of a source holding the issued time
//   halted       scheduler is in HALT
//   stop_hit     the current HALT was caused by the breakpoint
//   ovf          sticky: the scan minimum reached all-ones
//   event_count  issued events, wraps modulo 2^CNT_WIDTH
module emu_time_sched #(
    parameter int N_SRC      = 4,
    parameter int TIME_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        step_req,
    input  logic                        stop_en,
    input  logic [TIME_WIDTH-1:0]       stop_time,
    input  logic [N_SRC*TIME_WIDTH-1:0] src_time,
    output logic [TIME_WIDTH-1:0]       time_next,
    output logic                        emu_cke,
    output logic [$clog2(N_SRC)-1:0]    min_idx,
    output logic                        halted,
    output logic                        stop_hit,
    output logic                        ovf,
    output logic [CNT_WIDTH-1:0]        event_count
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

    typedef enum logic [1:0] {
        S_HALT,
        S_SCAN,
        S_ISSUE,
        S_SETTLE
    } state_t;

    state_t                  state, next_state;
    logic [IDX_W-1:0]        scan_idx;
    logic [TIME_WIDTH-1:0]   min_val;
    logic [IDX_W-1:0]        min_i;
    logic                    one_shot;
    logic [TIME_WIDTH-1:0]   src_arr [N_SRC];
    logic [TIME_WIDTH-1:0]   src_sel;
    logic                    min_all_ones;
    logic                    bp_hit;
    logic                    start;

    // Unpack the source bus so the scan can index it by source number.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_arr[i] = src_time[i*TIME_WIDTH +: TIME_WIDTH];
        end
    end

    assign src_sel      = src_arr[scan_idx];
    assign min_all_ones = &min_val;
    // step_req with run=1 is simply a run; ovf pins the FSM in HALT.
    assign start        = !ovf && (run || step_req);

`ifdef EMU_TIME_SCHED_BREAKPOINT_EN
    // Equality with stop_time is still issued; only a later time stops.
    assign bp_hit = stop_en && (min_val > stop_time);
`else
    assign bp_hit = 1'b0;
    logic unused_bp;
    assign unused_bp = &{1'b0, stop_en, stop_time};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HALT;
        else      state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_HALT:   if (start) next_state = S_SCAN;
            S_SCAN:   if (scan_idx == LAST_IDX) next_state = S_ISSUE;
            S_ISSUE:  next_state = (min_all_ones || bp_hit) ? S_HALT : S_SETTLE;
            S_SETTLE: next_state = (run && !one_shot) ? S_SCAN : S_HALT;
            default:  next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_next   <= '1;
            emu_cke     <= 1'b0;
            min_idx     <= '0;
            halted      <= 1'b1;
            stop_hit    <= 1'b0;
            ovf         <= 1'b0;
            event_count <= '0;
            scan_idx    <= '0;
            min_val     <= '1;
            min_i       <= '0;
            one_shot    <= 1'b0;
        end else begin
            emu_cke <= 1'b0;
            halted  <= (next_state == S_HALT);
            case (state)
                S_HALT: begin
                    scan_idx <= '0;
                    if (start) begin
                        stop_hit <= 1'b0;
                        one_shot <= !run;
                    end
                end
                S_SCAN: begin
                    // Slot 0 seeds the running minimum; later slots replace it
                    // only on a strictly smaller time, so ties keep the lower index.
                    if (scan_idx == '0 || src_sel < min_val) begin
                        min_val <= src_sel;
                        min_i   <= scan_idx;
                    end
                    scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
                end
                S_ISSUE: begin
                    if (min_all_ones) begin
                        ovf <= 1'b1;
                    end else if (bp_hit) begin
                        stop_hit <= 1'b1;
                    end else begin
                        time_next   <= min_val;
                        min_idx     <= min_i;
                        emu_cke     <= 1'b1;
                        event_count <= event_count + CNT_WIDTH'(1);
                    end
                end
                S_SETTLE: begin
                    if (!(run && !one_shot)) one_shot <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
